// File: rtl/cpu_mem_port_if.sv
// Execute-unit request/completion lines plus the memory and I/O bus signals
// served by cpu_mem_port.
interface cpu_mem_port_if #(
  parameter int RV = 16,
  parameter int VA = RV
) ();
  logic          ifetch;
  logic [VA-2:0] pc;
  logic [1:0]    rstrobe;
  logic [1:0]    wmask;
  logic [VA-2:0] addr;
  logic [RV-1:0] wdata;
  logic          io_access;
  logic          idone, rdone, wdone;
  logic [RV-1:0] idata, rdata;
  logic          bus_err;

  logic          mem_req, mem_we;
  logic [VA-2:0] mem_addr;
  logic [1:0]    mem_be;
  logic [RV-1:0] mem_wdata, mem_rdata;
  logic          mem_ack;

  logic          io_req, io_we;
  logic [VA-2:0] io_addr;
  logic [1:0]    io_be;
  logic [RV-1:0] io_wdata, io_rdata;
  logic          io_ack;

  modport slave (
    input  ifetch, pc, rstrobe, wmask, addr, wdata, io_access,
    output idone, rdone, wdone, idata, rdata, bus_err,
    output mem_req, mem_we, mem_addr, mem_be, mem_wdata,
    input  mem_rdata, mem_ack,
    output io_req, io_we, io_addr, io_be, io_wdata,
    input  io_rdata, io_ack
  );

  modport master (
    output ifetch, pc, rstrobe, wmask, addr, wdata, io_access,
    input  idone, rdone, wdone, idata, rdata, bus_err,
    input  mem_req, mem_we, mem_addr, mem_be, mem_wdata,
    output mem_rdata, mem_ack,
    input  io_req, io_we, io_addr, io_be, io_wdata,
    output io_rdata, io_ack
  );
endinterface

// File: rtl/cpu_mem_port.sv
// Serves execute-unit fetch/read/write requests one at a time on the memory or
// I/O bus, with a per-access timeout and one-cycle completion pulses.
module cpu_mem_port #(
  parameter int RV      = 16,
  parameter int VA      = RV,
  parameter int TIMEOUT = 255
) (
  input logic            clk,
  input logic            reset,
  cpu_mem_port_if.slave  bus
);
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
  typedef enum logic [1:0] {K_F, K_R, K_W} kind_t;

  localparam logic [7:0] TLAST = 8'(TIMEOUT - 1);

  state_t        state;
  kind_t         kind;
  logic          tgt_io;
  logic [1:0]    be_q;
  logic [7:0]    cnt;

  kind_t         nkind;
  logic          nio;
  logic [VA-2:0] naddr;
  logic [1:0]    nbe;
  logic          req_any;
  logic          ack_sel;
  logic [RV-1:0] rd_sel;

  // Byte reads return the selected byte replicated in both halves.
  function automatic logic [RV-1:0] fmt(input logic [1:0] be, input logic [RV-1:0] d);
    case (be)
      2'b01:   fmt = {d[7:0], d[7:0]};
      2'b10:   fmt = {d[15:8], d[15:8]};
      default: fmt = d;
    endcase
  endfunction

  always_comb begin
    nkind = K_F;
    nio   = 1'b0;
    naddr = bus.pc;
    nbe   = 2'b11;
    if (|bus.wmask) begin
      nkind = K_W; nio = bus.io_access; naddr = bus.addr; nbe = bus.wmask;
    end else if (|bus.rstrobe) begin
      nkind = K_R; nio = bus.io_access; naddr = bus.addr; nbe = bus.rstrobe;
    end
  end

  assign req_any = (|bus.wmask) || (|bus.rstrobe) || bus.ifetch;
  assign ack_sel = tgt_io ? bus.io_ack : bus.mem_ack;
  assign rd_sel  = tgt_io ? bus.io_rdata : bus.mem_rdata;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state         <= IDLE;
      kind          <= K_F;
      tgt_io        <= 1'b0;
      be_q          <= 2'b00;
      cnt           <= '0;
      bus.idone     <= 1'b0;
      bus.rdone     <= 1'b0;
      bus.wdone     <= 1'b0;
      bus.bus_err   <= 1'b0;
      bus.idata     <= '0;
      bus.rdata     <= '0;
      bus.mem_req   <= 1'b0;
      bus.mem_we    <= 1'b0;
      bus.mem_addr  <= '0;
      bus.mem_be    <= '0;
      bus.mem_wdata <= '0;
      bus.io_req    <= 1'b0;
      bus.io_we     <= 1'b0;
      bus.io_addr   <= '0;
      bus.io_be     <= '0;
      bus.io_wdata  <= '0;
    end else begin
      bus.idone   <= 1'b0;
      bus.rdone   <= 1'b0;
      bus.wdone   <= 1'b0;
      bus.bus_err <= 1'b0;
      case (state)
        IDLE: if (req_any) begin
          kind   <= nkind;
          tgt_io <= nio;
          be_q   <= nbe;
          cnt    <= '0;
          state  <= BUSY;
          // Only the selected bus is driven; the other keeps its last values.
          if (nio) begin
            bus.io_req   <= 1'b1;
            bus.io_we    <= (nkind == K_W);
            bus.io_addr  <= naddr;
            bus.io_be    <= nbe;
            bus.io_wdata <= bus.wdata;
          end else begin
            bus.mem_req   <= 1'b1;
            bus.mem_we    <= (nkind == K_W);
            bus.mem_addr  <= naddr;
            bus.mem_be    <= nbe;
            bus.mem_wdata <= bus.wdata;
          end
        end
        BUSY: begin
          if (ack_sel || cnt == TLAST) begin
            // The done pulse is registered here so it is visible during DONE.
            bus.mem_req <= 1'b0;
            bus.mem_we  <= 1'b0;
            bus.io_req  <= 1'b0;
            bus.io_we   <= 1'b0;
            bus.bus_err <= !ack_sel;
            state       <= DONE;
            case (kind)
              K_W: bus.wdone <= 1'b1;
              K_R: begin
                bus.rdone <= 1'b1;
                bus.rdata <= ack_sel ? fmt(be_q, rd_sel) : '1;
              end
              default: begin
                bus.idone <= 1'b1;
                bus.idata <= ack_sel ? rd_sel : '1;
              end
            endcase
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        // Request lines are stale while the done pulse is out; ignore them.
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_cpu_mem_port.sv
// Directed bench for cpu_mem_port (TIMEOUT=4): fetch, byte reads, I/O write,
// priority, timeout, last-cycle ack and reset mid-access.
module tb_cpu_mem_port;
  logic clk = 1'b0;
  logic reset;
  int   vectors = 0;
  int   errs = 0;

  always #5 clk = ~clk;

  cpu_mem_port_if #(.RV(16), .VA(16)) b ();

  cpu_mem_port #(.RV(16), .VA(16), .TIMEOUT(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (b.slave)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [127:0] all_out();
    return {b.idone, b.rdone, b.wdone, b.bus_err, b.idata, b.rdata,
            b.mem_req, b.mem_we, b.mem_addr, b.mem_be, b.mem_wdata,
            b.io_req, b.io_we, b.io_addr, b.io_be, b.io_wdata};
  endfunction

  task automatic clr();
    b.ifetch = 0; b.rstrobe = 0; b.wmask = 0; b.io_access = 0;
    b.mem_ack = 0; b.io_ack = 0;
  endtask

  initial begin
    reset = 1'b0;
    b.pc = '0; b.addr = '0; b.wdata = '0; b.mem_rdata = '0; b.io_rdata = '0;
    clr();
    step(); step();
    chk("reset_outputs", all_out(), '0);
    reset = 1'b1;
    step();

    // word fetch, ack in first req cycle
    b.ifetch = 1; b.pc = 15'h0002;
    step();
    chk("fetch_req", {b.mem_req, b.mem_we, b.mem_addr, b.mem_be, b.io_req},
        {1'b1, 1'b0, 15'h0002, 2'b11, 1'b0});
    b.mem_ack = 1; b.mem_rdata = 16'h1234;
    step();
    chk("fetch_done", {b.idone, b.rdone, b.wdone, b.bus_err, b.idata, b.mem_req},
        {4'b1000, 16'h1234, 1'b0});
    clr();
    step();
    chk("fetch_pulse_1cyc", b.idone, 1'b0);

    // byte read hi, ack after 3 wait cycles
    b.rstrobe = 2'b10; b.addr = 15'h0100; b.mem_rdata = 16'hAB12;
    step();
    chk("rd_hi_req", {b.mem_req, b.mem_be, b.mem_addr}, {1'b1, 2'b10, 15'h0100});
    step(); step(); step();
    chk("rd_hi_wait", {b.mem_req, b.rdone}, {1'b1, 1'b0});
    b.mem_ack = 1;
    step();
    chk("rd_hi_done", {b.rdone, b.bus_err, b.rdata}, {2'b10, 16'hABAB});
    clr();
    step();

    // byte read lo
    b.rstrobe = 2'b01;
    step();
    b.mem_ack = 1;
    step();
    chk("rd_lo_done", {b.rdone, b.bus_err, b.rdata}, {2'b10, 16'h1212});
    clr();
    step();

    // I/O write; a stray memory ack must be ignored
    b.io_access = 1; b.wmask = 2'b01; b.wdata = 16'h5555; b.addr = 15'h0040;
    step();
    chk("io_wr_req", {b.io_req, b.io_we, b.io_be, b.io_addr, b.io_wdata, b.mem_req},
        {1'b1, 1'b1, 2'b01, 15'h0040, 16'h5555, 1'b0});
    b.mem_ack = 1;
    step();
    chk("io_wr_ignore_mem_ack", {b.wdone, b.io_req}, {1'b0, 1'b1});
    b.mem_ack = 0; b.io_ack = 1;
    step();
    chk("io_wr_done", {b.wdone, b.bus_err, b.io_req, b.io_we}, 4'b1000);
    clr();
    step();
    chk("io_wr_pulse_1cyc", b.wdone, 1'b0);

    // write beats simultaneous fetch; stale wmask in DONE is ignored
    b.ifetch = 1; b.wmask = 2'b11; b.wdata = 16'hA5A5; b.addr = 15'h0010; b.pc = 15'h0020;
    step();
    chk("prio_wr_req", {b.mem_req, b.mem_we, b.mem_addr, b.mem_be, b.mem_wdata},
        {1'b1, 1'b1, 15'h0010, 2'b11, 16'hA5A5});
    b.mem_ack = 1;
    step();
    chk("prio_wr_done", {b.wdone, b.idone}, 2'b10);
    b.mem_ack = 0;
    step();
    chk("prio_gap", b.mem_req, 1'b0);
    b.wmask = 0;
    step();
    chk("prio_fetch_req", {b.mem_req, b.mem_we, b.mem_addr, b.mem_be},
        {1'b1, 1'b0, 15'h0020, 2'b11});
    b.mem_ack = 1; b.mem_rdata = 16'hBEEF;
    step();
    chk("prio_fetch_done", {b.idone, b.wdone, b.idata}, {2'b10, 16'hBEEF});
    clr();
    step();

    // read timeout
    b.rstrobe = 2'b11; b.addr = 15'h0007;
    step(); step(); step(); step();
    chk("to_rd_req_c4", {b.mem_req, b.rdone}, 2'b10);
    step();
    chk("to_rd_done", {b.rdone, b.bus_err, b.rdata, b.mem_req}, {2'b11, 16'hFFFF, 1'b0});
    clr();
    step();
    chk("to_rd_after", {b.rdone, b.bus_err, b.rdata}, {2'b00, 16'hFFFF});

    // fetch timeout
    b.ifetch = 1;
    step(); step(); step(); step(); step();
    chk("to_fetch_done", {b.idone, b.bus_err, b.idata}, {2'b11, 16'hFFFF});
    clr();
    step();

    // I/O read with ack in the final permitted cycle
    b.io_access = 1; b.rstrobe = 2'b11; b.io_rdata = 16'h4321; b.addr = 15'h0055;
    step();
    chk("io_rd_req", {b.io_req, b.io_we, b.io_addr, b.mem_req}, {2'b10, 15'h0055, 1'b0});
    step(); step(); step();
    b.io_ack = 1;
    step();
    chk("io_rd_last_ack", {b.rdone, b.bus_err, b.rdata}, {2'b10, 16'h4321});
    clr();
    step();

    // reset mid-access, then a late ack
    b.ifetch = 1; b.pc = 15'h0033;
    step();
    chk("rst_busy_req", b.mem_req, 1'b1);
    reset = 1'b0;
    step();
    chk("rst_mid_outputs", all_out(), '0);
    reset = 1'b1; b.ifetch = 0; b.mem_ack = 1;
    step(); step();
    chk("rst_late_ack", {b.idone, b.rdone, b.wdone, b.bus_err, b.mem_req}, 5'b0);
    clr();
    step();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end
endmodule
